psram_async_responder: RTL and testbench

//  Synthesizable responder for the async CellularRAM bus (ADV-latched address/data mux, CE/OE/WE/UB/LB).

---
 rtl/psram_async_responder.sv | 200 ++++++++++++++++++++
 tb/tb_psram_async_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_async_responder.sv
// Async CellularRAM bank responder: latches the ADV-muxed address, commits byte-masked writes
// to an internal word RAM, returns read data after a programmable access latency, and flags bus misuse.
module psram_async_responder #(
    parameter int unsigned BANK           = 0,
    parameter int unsigned MEM_ADDR_BITS  = 10,
    parameter int unsigned ACCESS_CYCLES  = 8,
    parameter int unsigned MIN_ADV_CYCLES = 1,
    parameter int unsigned MIN_WE_CYCLES  = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  cram_a,
    inout  wire  [15:0] cram_dq,
    output logic        cram_wait,
    input  logic        cram_clk,
    input  logic        cram_adv_n,
    input  logic        cram_cre,
    input  logic        cram_ce0_n,
    input  logic        cram_ce1_n,
    input  logic        cram_oe_n,
    input  logic        cram_we_n,
    input  logic        cram_ub_n,
    input  logic        cram_lb_n,
    output logic        mon_write,
    output logic        mon_read,
    output logic [21:0] mon_addr,
    output logic [15:0] mon_data,
    output logic [3:0]  err_flags
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, LATCH, ACTIVE, WRITE, READ, ABORT} state_t;

    state_t               state_q, state_d;
    logic [21:0]          addr_q, addr_d;
    logic [CNT_W-1:0]     access_cnt_q, access_cnt_d;
    logic [CNT_W-1:0]     adv_cnt_q, adv_cnt_d;
    logic [CNT_W-1:0]     we_cnt_q, we_cnt_d;
    logic [15:0]          wdata_q, wdata_d, rdata_q;
    logic [1:0]           be_q, be_d;
    logic                 ce_c, start_c, commit_c, drive_c, read_seen_q;
    logic [3:0]           err_set_c;
    logic [15:0]          mem [DEPTH];
    logic [MEM_ADDR_BITS-1:0] idx_c;
    logic                 unused_clk;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign ce_c       = (BANK == 0) ? ~cram_ce0_n : ~cram_ce1_n;
    assign idx_c      = addr_q[MEM_ADDR_BITS-1:0];
    assign cram_wait  = 1'b0;
    assign unused_clk = cram_clk;

    // Only the enable is combinational so dq lets go in the same cycle oe_n rises.
    assign drive_c = (state_q == READ) & ce_c & ~cram_oe_n & cram_we_n &
                     (access_cnt_q >= CNT_W'(ACCESS_CYCLES));
    assign cram_dq[15:8] = (drive_c & ~cram_ub_n) ? rdata_q[15:8] : 8'bz;
    assign cram_dq[7:0]  = (drive_c & ~cram_lb_n) ? rdata_q[7:0]  : 8'bz;

    // Next-state, counters and error events
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        access_cnt_d = access_cnt_q;
        adv_cnt_d    = adv_cnt_q;
        we_cnt_d     = we_cnt_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        start_c      = 1'b0;
        commit_c     = 1'b0;
        err_set_c    = '0;
        err_set_c[2] = ce_c & ~cram_oe_n & (~cram_adv_n | ~cram_we_n);

        if (!ce_c) begin
            state_d  = IDLE;
            commit_c = (state_q == WRITE);
        end else begin
            case (state_q)
                IDLE: start_c = ~cram_adv_n;
                LATCH: begin
                    access_cnt_d = sat_inc(access_cnt_q);
                    if (cram_cre) begin
                        state_d      = ABORT;
                        err_set_c[3] = 1'b1;
                    end else if (!cram_adv_n) begin
                        addr_d    = {cram_a, cram_dq};
                        adv_cnt_d = sat_inc(adv_cnt_q);
                    end else begin
                        state_d      = ACTIVE;
                        err_set_c[0] = (adv_cnt_q < CNT_W'(MIN_ADV_CYCLES));
                    end
                end
                ACTIVE: begin
                    if (!cram_adv_n) begin
                        start_c = 1'b1;
                    end else begin
                        access_cnt_d = sat_inc(access_cnt_q);
                        if (!cram_we_n) begin
                            state_d  = WRITE;
                            we_cnt_d = CNT_W'(1);
                            wdata_d  = cram_dq;
                            be_d     = {~cram_ub_n, ~cram_lb_n};
                        end else if (!cram_oe_n) begin
                            state_d = READ;
                        end
                    end
                end
                WRITE: begin
                    if (!cram_adv_n) begin
                        start_c = 1'b1;
                    end else begin
                        access_cnt_d = sat_inc(access_cnt_q);
                        if (!cram_we_n) begin
                            we_cnt_d = sat_inc(we_cnt_q);
                            wdata_d  = cram_dq;
                            be_d     = {~cram_ub_n, ~cram_lb_n};
                        end else begin
                            commit_c = 1'b1;
                            state_d  = ACTIVE;
                        end
                    end
                end
                READ: begin
                    if (!cram_adv_n) begin
                        start_c = 1'b1;
                    end else begin
                        access_cnt_d = sat_inc(access_cnt_q);
                        if (cram_oe_n) state_d = ACTIVE;
                    end
                end
                ABORT:   state_d = ABORT;
                default: state_d = IDLE;
            endcase
        end

        // A fresh ADV pulse restarts the access from the latch phase.
        if (start_c) begin
            if (cram_cre) begin
                state_d      = ABORT;
                err_set_c[3] = 1'b1;
            end else begin
                state_d      = LATCH;
                addr_d       = {cram_a, cram_dq};
                access_cnt_d = CNT_W'(1);
                adv_cnt_d    = CNT_W'(1);
            end
        end
        err_set_c[1] = commit_c & (we_cnt_q < CNT_W'(MIN_WE_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            access_cnt_q <= '0;
            adv_cnt_q    <= '0;
            we_cnt_q     <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            read_seen_q  <= 1'b0;
            mon_write    <= 1'b0;
            mon_read     <= 1'b0;
            mon_addr     <= '0;
            mon_data     <= '0;
            err_flags    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            access_cnt_q <= access_cnt_d;
            adv_cnt_q    <= adv_cnt_d;
            we_cnt_q     <= we_cnt_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            read_seen_q  <= (state_d == READ) && (read_seen_q || drive_c);
            mon_write    <= commit_c;
            mon_read     <= drive_c & ~read_seen_q;
            if (commit_c) begin
                mon_addr <= addr_q;
                mon_data <= wdata_q;
            end else if (drive_c && !read_seen_q) begin
                mon_addr <= addr_q;
                mon_data <= rdata_q;
            end
            err_flags <= err_flags | err_set_c;
        end
    end

    // Word RAM; contents survive reset, and a reset cycle never commits.
    always_ff @(posedge clk) begin
        if (reset_n && commit_c) begin
            if (be_q[1]) mem[idx_c][15:8] <= wdata_q[15:8];
            if (be_q[0]) mem[idx_c][7:0]  <= wdata_q[7:0];
        end
        rdata_q <= mem[idx_c];
    end
endmodule

// File: tb/tb_psram_async_responder.sv
// Two responder banks on one shared CellularRAM bus, driven by a bus-level controller model
// and checked against a per-bank word-array reference.
module tb_psram_async_responder;
    localparam int unsigned ACC   = 8;
    localparam logic [7:0]  FLOAT = 8'hFF;

    logic        clk, reset_n, cram_clk, adv_n, cre, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n;
    logic [5:0]  cram_a;
    wire  [15:0] cram_dq;
    logic [15:0] dq_drv;
    logic        dq_oe;
    logic [1:0]  cram_wait, mon_write, mon_read;
    logic [21:0] mon_addr [2];
    logic [15:0] mon_data [2];
    logic [3:0]  err [2];

    logic [15:0] model [2][1024];
    int          wr_cnt [2], rd_cnt [2];
    logic [21:0] obs_addr [2];
    logic [15:0] obs_data [2];
    logic [15:0] obs_dq [32];
    logic [15:0] rel_dq;
    int          n_checks, n_pass;

    assign cram_dq = dq_oe ? dq_drv : 16'hzzzz;
    pullup (cram_dq);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    psram_async_responder #(.BANK(0)) u_bank0 (
        .clk(clk), .reset_n(reset_n), .cram_a(cram_a), .cram_dq(cram_dq), .cram_wait(cram_wait[0]),
        .cram_clk(cram_clk), .cram_adv_n(adv_n), .cram_cre(cre), .cram_ce0_n(ce0_n), .cram_ce1_n(ce1_n),
        .cram_oe_n(oe_n), .cram_we_n(we_n), .cram_ub_n(ub_n), .cram_lb_n(lb_n),
        .mon_write(mon_write[0]), .mon_read(mon_read[0]), .mon_addr(mon_addr[0]),
        .mon_data(mon_data[0]), .err_flags(err[0]));

    psram_async_responder #(.BANK(1)) u_bank1 (
        .clk(clk), .reset_n(reset_n), .cram_a(cram_a), .cram_dq(cram_dq), .cram_wait(cram_wait[1]),
        .cram_clk(cram_clk), .cram_adv_n(adv_n), .cram_cre(cre), .cram_ce0_n(ce0_n), .cram_ce1_n(ce1_n),
        .cram_oe_n(oe_n), .cram_we_n(we_n), .cram_ub_n(ub_n), .cram_lb_n(lb_n),
        .mon_write(mon_write[1]), .mon_read(mon_read[1]), .mon_addr(mon_addr[1]),
        .mon_data(mon_data[1]), .err_flags(err[1]));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ce(input int b, input logic v);
        if (b == 0) ce0_n = v;
        else        ce1_n = v;
    endtask

    task automatic bus_idle();
        ce0_n = 1'b1; ce1_n = 1'b1; adv_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        ub_n = 1'b1; lb_n = 1'b1; cre = 1'b0; cram_a = '0; dq_drv = '0; dq_oe = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus_idle();
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic clear_obs();
        for (int b = 0; b < 2; b++) begin
            wr_cnt[b] = 0; rd_cnt[b] = 0; obs_addr[b] = '0; obs_data[b] = '0;
        end
    endtask

    task automatic observe();
        for (int b = 0; b < 2; b++) begin
            if (mon_write[b]) begin wr_cnt[b]++; obs_addr[b] = mon_addr[b]; obs_data[b] = mon_data[b]; end
            if (mon_read[b])  begin rd_cnt[b]++; obs_addr[b] = mon_addr[b]; obs_data[b] = mon_data[b]; end
        end
    endtask

    task automatic model_write(input int b, input logic [21:0] a, input logic [15:0] d,
                               input logic u_n, input logic l_n);
        if (!u_n) model[b][a[9:0]][15:8] = d[15:8];
        if (!l_n) model[b][a[9:0]][7:0]  = d[7:0];
    endtask

    // Controller write: 1-clk ADV, then we_n low for we_len clocks, dq released as we_n rises.
    task automatic write_access(input int b, input logic [21:0] a, input logic [15:0] d,
                                input logic u_n, input logic l_n, input int we_len);
        clear_obs();
        set_ce(b, 1'b0); adv_n = 1'b0; cram_a = a[21:16]; dq_drv = a[15:0]; dq_oe = 1'b1;
        tick(); observe();
        adv_n = 1'b1; dq_drv = d;
        tick(); observe();
        we_n = 1'b0; ub_n = u_n; lb_n = l_n;
        repeat (we_len) begin tick(); observe(); end
        we_n = 1'b1; dq_oe = 1'b0;
        tick(); observe();
        set_ce(b, 1'b1); ub_n = 1'b1; lb_n = 1'b1;
        tick(); observe();
        tick(); observe();
    endtask

    // Controller read: ADV on edge 1, oe_n first sampled low on edge k_oe, bus observed after edges 2..n_edges.
    task automatic read_access(input int b, input logic [21:0] a, input int k_oe, input int n_edges,
                               input logic u_n, input logic l_n);
        clear_obs();
        set_ce(b, 1'b0); adv_n = 1'b0; cram_a = a[21:16]; dq_drv = a[15:0]; dq_oe = 1'b1;
        ub_n = u_n; lb_n = l_n;
        tick(); observe();
        adv_n = 1'b1; dq_oe = 1'b0;
        for (int n = 2; n <= n_edges; n++) begin
            oe_n = (n >= k_oe) ? 1'b0 : 1'b1;
            tick(); observe();
            obs_dq[n] = cram_dq;
        end
        oe_n = 1'b1;
        #1 rel_dq = cram_dq;
        set_ce(b, 1'b1); ub_n = 1'b1; lb_n = 1'b1;
        tick(); observe();
        tick(); observe();
    endtask

    // Bus value after edge n: data appears once ACC clocks have elapsed since ADV and oe_n has been seen.
    function automatic logic [15:0] exp_dq(input int n, input int k_oe, input logic [15:0] w,
                                           input logic u_n, input logic l_n, input bit live);
        bit on;
        on = live && (n >= ACC) && (n >= k_oe);
        return {(on && !u_n) ? w[15:8] : FLOAT, (on && !l_n) ? w[7:0] : FLOAT};
    endfunction

    task automatic test_reset();
        do_reset();
        for (int b = 0; b < 2; b++) begin
            n_checks++; if (mon_write[b] !== 1'b0) $display("FAIL reset_mon_write b%0d got=%b exp=0", b, mon_write[b]); else n_pass++;
            n_checks++; if (mon_read[b] !== 1'b0) $display("FAIL reset_mon_read b%0d got=%b exp=0", b, mon_read[b]); else n_pass++;
            n_checks++; if (mon_addr[b] !== 22'h0) $display("FAIL reset_mon_addr b%0d got=%h exp=0", b, mon_addr[b]); else n_pass++;
            n_checks++; if (mon_data[b] !== 16'h0) $display("FAIL reset_mon_data b%0d got=%h exp=0", b, mon_data[b]); else n_pass++;
            n_checks++; if (err[b] !== 4'h0) $display("FAIL reset_err b%0d got=%h exp=0", b, err[b]); else n_pass++;
            n_checks++; if (cram_wait[b] !== 1'b0) $display("FAIL reset_wait b%0d got=%b exp=0", b, cram_wait[b]); else n_pass++;
        end
        n_checks++; if (cram_dq !== 16'hFFFF) $display("FAIL reset_dq_released got=%h exp=ffff", cram_dq); else n_pass++;
    endtask

    task automatic test_write_read();
        write_access(0, 22'h000010, 16'h1234, 1'b0, 1'b0, 9);
        model_write(0, 22'h000010, 16'h1234, 1'b0, 1'b0);
        n_checks++; if (wr_cnt[0] != 1) $display("FAIL wr_pulse got=%0d exp=1", wr_cnt[0]); else n_pass++;
        n_checks++; if (wr_cnt[1] != 0) $display("FAIL wr_pulse_other got=%0d exp=0", wr_cnt[1]); else n_pass++;
        n_checks++; if (obs_addr[0] !== 22'h000010) $display("FAIL wr_addr got=%h exp=000010", obs_addr[0]); else n_pass++;
        n_checks++; if (obs_data[0] !== 16'h1234) $display("FAIL wr_data got=%h exp=1234", obs_data[0]); else n_pass++;
        n_checks++; if (err[0] !== 4'h0) $display("FAIL wr_err got=%h exp=0", err[0]); else n_pass++;

        read_access(0, 22'h000010, 3, 10, 1'b0, 1'b0);
        for (int n = 2; n <= 10; n++) begin
            n_checks++;
            if (obs_dq[n] !== exp_dq(n, 3, 16'h1234, 1'b0, 1'b0, 1'b1))
                $display("FAIL rd_latency edge=%0d got=%h exp=%h", n, obs_dq[n], exp_dq(n, 3, 16'h1234, 1'b0, 1'b0, 1'b1));
            else n_pass++;
        end
        n_checks++; if (rd_cnt[0] != 1) $display("FAIL rd_pulse got=%0d exp=1", rd_cnt[0]); else n_pass++;
        n_checks++; if (obs_data[0] !== 16'h1234) $display("FAIL rd_mon_data got=%h exp=1234", obs_data[0]); else n_pass++;
        n_checks++; if (obs_addr[0] !== 22'h000010) $display("FAIL rd_mon_addr got=%h exp=000010", obs_addr[0]); else n_pass++;
        n_checks++; if (rel_dq !== 16'hFFFF) $display("FAIL rd_release got=%h exp=ffff", rel_dq); else n_pass++;
    endtask

    task automatic test_byte_mask();
        write_access(0, 22'h000010, 16'hAB00, 1'b0, 1'b1, 9);
        model_write(0, 22'h000010, 16'hAB00, 1'b0, 1'b1);
        read_access(0, 22'h000010, 4, 11, 1'b0, 1'b0);
        n_checks++; if (obs_dq[11] !== 16'hAB34) $display("FAIL mask_merge got=%h exp=ab34", obs_dq[11]); else n_pass++;
        read_access(0, 22'h000010, 3, 10, 1'b1, 1'b0);
        for (int n = 2; n <= 10; n++) begin
            n_checks++;
            if (obs_dq[n] !== exp_dq(n, 3, model[0][16], 1'b1, 1'b0, 1'b1))
                $display("FAIL mask_ub_off edge=%0d got=%h exp=%h", n, obs_dq[n], exp_dq(n, 3, model[0][16], 1'b1, 1'b0, 1'b1));
            else n_pass++;
        end
        n_checks++; if (obs_dq[10] !== {FLOAT, 8'h34}) $display("FAIL mask_low_byte got=%h exp=ff34", obs_dq[10]); else n_pass++;
    endtask

    task automatic test_we_short();
        write_access(0, 22'h000020, 16'h5A5A, 1'b0, 1'b0, 3);
        model_write(0, 22'h000020, 16'h5A5A, 1'b0, 1'b0);
        n_checks++; if (wr_cnt[0] != 1) $display("FAIL short_commit got=%0d exp=1", wr_cnt[0]); else n_pass++;
        n_checks++; if (err[0] !== 4'b0010) $display("FAIL short_err got=%b exp=0010", err[0]); else n_pass++;
        read_access(0, 22'h000020, 3, 9, 1'b0, 1'b0);
        n_checks++; if (obs_dq[9] !== 16'h5A5A) $display("FAIL short_data got=%h exp=5a5a", obs_dq[9]); else n_pass++;
        write_access(0, 22'h000021, 16'h0F0E, 1'b0, 1'b0, 9);
        model_write(0, 22'h000021, 16'h0F0E, 1'b0, 1'b0);
        n_checks++; if (err[0] !== 4'b0010) $display("FAIL short_sticky got=%b exp=0010", err[0]); else n_pass++;
        do_reset();
        n_checks++; if (err[0] !== 4'h0) $display("FAIL short_reset_clear got=%b exp=0000", err[0]); else n_pass++;
        read_access(0, 22'h000020, 5, 9, 1'b0, 1'b0);
        n_checks++; if (obs_dq[9] !== model[0][32]) $display("FAIL ram_kept got=%h exp=%h", obs_dq[9], model[0][32]); else n_pass++;
    endtask

    task automatic test_conflict();
        set_ce(0, 1'b0); adv_n = 1'b0; oe_n = 1'b0; cram_a = '0; dq_drv = 16'h0030; dq_oe = 1'b1;
        tick();
        dq_oe = 1'b0;
        #1;
        n_checks++; if (cram_dq !== 16'hFFFF) $display("FAIL latch_no_drive got=%h exp=ffff", cram_dq); else n_pass++;
        adv_n = 1'b1;
        tick();
        oe_n = 1'b1; set_ce(0, 1'b1);
        tick(); tick();
        n_checks++; if (err[0] !== 4'b0100) $display("FAIL conflict_err got=%b exp=0100", err[0]); else n_pass++;
        n_checks++; if (err[1] !== 4'b0000) $display("FAIL conflict_other got=%b exp=0000", err[1]); else n_pass++;
        do_reset();
    endtask

    task automatic test_cre();
        cre = 1'b1;
        write_access(0, 22'h000010, 16'h7776, 1'b0, 1'b0, 9);
        n_checks++; if (wr_cnt[0] != 0) $display("FAIL cre_no_commit got=%0d exp=0", wr_cnt[0]); else n_pass++;
        read_access(0, 22'h000010, 3, 11, 1'b0, 1'b0);
        for (int n = 2; n <= 11; n++) begin
            n_checks++;
            if (obs_dq[n] !== exp_dq(n, 3, 16'h0, 1'b0, 1'b0, 1'b0))
                $display("FAIL cre_no_drive edge=%0d got=%h exp=ffff", n, obs_dq[n]);
            else n_pass++;
        end
        n_checks++; if (rd_cnt[0] != 0) $display("FAIL cre_no_read got=%0d exp=0", rd_cnt[0]); else n_pass++;
        n_checks++; if (err[0] !== 4'b1000) $display("FAIL cre_err got=%b exp=1000", err[0]); else n_pass++;
        cre = 1'b0;
        read_access(0, 22'h000010, 3, 9, 1'b0, 1'b0);
        n_checks++; if (obs_dq[9] !== model[0][16]) $display("FAIL cre_ram_kept got=%h exp=%h", obs_dq[9], model[0][16]); else n_pass++;
        do_reset();
    endtask

    task automatic test_random_banks();
        logic [9:0]  pool [4];
        logic [21:0] a;
        logic [15:0] d;
        logic        u_n, l_n;
        int          b, sel, k, ne;
        pool[0] = 10'h000; pool[1] = 10'h3FF; pool[2] = 10'h155; pool[3] = 10'h2AA;
        for (int i = 0; i < 28; i++) begin
            b   = (i < 8) ? (i % 2) : int'($urandom_range(1, 0));
            a   = {12'($urandom), pool[(i < 8) ? (i / 2) : int'($urandom_range(3, 0))]};
            d   = 16'($urandom) & 16'hFEFE;
            sel = (i < 8) ? 0 : int'($urandom_range(2, 0));
            u_n = (sel == 2); l_n = (sel == 1);
            write_access(b, a, d, u_n, l_n, int'($urandom_range(12, 8)));
            model_write(b, a, d, u_n, l_n);
            n_checks++; if (wr_cnt[b] != 1 || wr_cnt[1-b] != 0)
                $display("FAIL rnd_wr_pulses b%0d got=%0d/%0d exp=1/0", b, wr_cnt[b], wr_cnt[1-b]); else n_pass++;
            n_checks++; if (obs_addr[b] !== a) $display("FAIL rnd_wr_addr got=%h exp=%h", obs_addr[b], a); else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            b   = int'($urandom_range(1, 0));
            a   = {12'($urandom), pool[$urandom_range(3, 0)]};
            sel = int'($urandom_range(2, 0));
            u_n = (sel == 2); l_n = (sel == 1);
            k   = int'($urandom_range(10, 3));
            ne  = ((k > int'(ACC)) ? k : int'(ACC)) + int'($urandom_range(3, 1));
            read_access(b, a, k, ne, u_n, l_n);
            for (int n = 2; n <= ne; n++) begin
                n_checks++;
                if (obs_dq[n] !== exp_dq(n, k, model[b][a[9:0]], u_n, l_n, 1'b1))
                    $display("FAIL rnd_rd b%0d addr=%h edge=%0d got=%h exp=%h", b, a, n, obs_dq[n],
                             exp_dq(n, k, model[b][a[9:0]], u_n, l_n, 1'b1));
                else n_pass++;
            end
            n_checks++; if (rd_cnt[b] != 1 || rd_cnt[1-b] != 0)
                $display("FAIL rnd_rd_pulses b%0d got=%0d/%0d exp=1/0", b, rd_cnt[b], rd_cnt[1-b]); else n_pass++;
            n_checks++; if (obs_addr[b] !== a) $display("FAIL rnd_rd_addr got=%h exp=%h", obs_addr[b], a); else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (err[i] !== 4'h0) $display("FAIL rnd_err b%0d got=%b exp=0000", i, err[i]); else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cram_clk = 1'b0;
        reset_n = 1'b0; bus_idle();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_mask();
        test_we_short();
        test_conflict();
        test_cre();
        test_random_banks();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
